// File: rtl/alu_issue_ctrl.sv
// Issue/collect front end for the 16-bit combinational ALU: one operation in flight,
// operands held for a per-function settle window, result returned over a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned ALU_CONTROL_WIDTH = 4,
    parameter int unsigned FAST_LAT          = 1,
    parameter int unsigned MULDIV_LAT        = 4,
    parameter int unsigned CNT_WIDTH         = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ALU_CONTROL_WIDTH-1:0] req_func,
    input  logic [DATA_WIDTH-1:0]        req_a,
    input  logic [DATA_WIDTH-1:0]        req_b,
    output logic [DATA_WIDTH-1:0]        alu_a,
    output logic [DATA_WIDTH-1:0]        alu_b,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0]        alu_r,
    input  logic [DATA_WIDTH-1:0]        alu_s,
    input  logic                         alu_exception,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DATA_WIDTH-1:0]        res_lo,
    output logic [DATA_WIDTH-1:0]        res_hi,
    output logic                         res_hi_we,
    output logic                         res_exc
);

    localparam logic [ALU_CONTROL_WIDTH-1:0] FUNC_NOP = ALU_CONTROL_WIDTH'(0);
    localparam logic [ALU_CONTROL_WIDTH-1:0] FUNC_MUL = ALU_CONTROL_WIDTH'(1);
    localparam logic [ALU_CONTROL_WIDTH-1:0] FUNC_DIV = ALU_CONTROL_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]         FAST_CNT   = CNT_WIDTH'(FAST_LAT - 1);
    localparam logic [CNT_WIDTH-1:0]         MULDIV_CNT = CNT_WIDTH'(MULDIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                         state, state_d;
    logic [CNT_WIDTH-1:0]           cnt, cnt_d;
    logic                           req_ready_d, res_valid_d;
    logic [DATA_WIDTH-1:0]          alu_a_d, alu_b_d;
    logic [ALU_CONTROL_WIDTH-1:0]   alu_ctrl_d;
    logic [DATA_WIDTH-1:0]          res_lo_d, res_hi_d;
    logic                           res_hi_we_d, res_exc_d;
    logic                           req_muldiv;
    logic                           cur_muldiv;

    assign req_muldiv = (req_func == FUNC_MUL) || (req_func == FUNC_DIV);
    assign cur_muldiv = (alu_ctrl == FUNC_MUL) || (alu_ctrl == FUNC_DIV);

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= FUNC_NOP;
            res_lo    <= '0;
            res_hi    <= '0;
            res_hi_we <= 1'b0;
            res_exc   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req_ready <= req_ready_d;
            res_valid <= res_valid_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_ctrl  <= alu_ctrl_d;
            res_lo    <= res_lo_d;
            res_hi    <= res_hi_d;
            res_hi_we <= res_hi_we_d;
            res_exc   <= res_exc_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        req_ready_d = req_ready;
        res_valid_d = res_valid;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_ctrl_d  = alu_ctrl;
        res_lo_d    = res_lo;
        res_hi_d    = res_hi;
        res_hi_we_d = res_hi_we;
        res_exc_d   = res_exc;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    alu_ctrl_d  = req_func;
                    cnt_d       = req_muldiv ? MULDIV_CNT : FAST_CNT;
                    req_ready_d = 1'b0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    res_lo_d    = alu_r;
                    res_hi_d    = alu_s;
                    res_exc_d   = alu_exception;
                    res_hi_we_d = cur_muldiv && !alu_exception;
                    // Park the ALU on NOP while the result waits for writeback.
                    alu_ctrl_d  = FUNC_NOP;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt - CNT_WIDTH'(1);
                end
            end
            S_RESP: begin
                if (res_valid && res_ready) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                req_ready_d = 1'b1;
                alu_ctrl_d  = FUNC_NOP;
                state_d     = S_IDLE;
            end
        endcase
    end

endmodule
